// File: rtl/pc_sequencer.sv
// Program-counter sequencer with INC/BR/JMP/CALL/RET and a return-address stack.
// New pc appears one cycle after the op is sampled; en=0 stalls every piece of state.
module pc_sequencer #(
    parameter int               WIDTH    = 16,
    parameter int               STEP     = 1,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                         CLK,
    input  logic                         Reset,
    input  logic                         en,
    input  logic [2:0]                   op,
    input  logic                         cond,
    input  logic [WIDTH-1:0]             target,
    output logic [WIDTH-1:0]             pc,
    output logic [$clog2(DEPTH+1)-1:0]   ras_count,
    output logic                         ras_full,
    output logic                         ras_empty,
    output logic                         err
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_BR   = 3'd1;
    localparam logic [2:0] OP_JMP  = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;

    logic [WIDTH-1:0] pc_q, pc_d, pc_seq;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             push;
    logic [AW-1:0]    wr_idx, rd_idx;
    logic [WIDTH-1:0] stack_q [2**AW];

    assign pc_seq    = pc_q + WIDTH'(STEP);
    assign wr_idx    = AW'(cnt_q);
    assign rd_idx    = AW'(cnt_q - CW'(1));
    assign ras_full  = (cnt_q == CW'(DEPTH));
    assign ras_empty = (cnt_q == '0);

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        err_d = err_q;
        push  = 1'b0;
        if (en) begin
            case (op)
                // Same-width add is the sign-extended offset modulo 2^WIDTH.
                OP_BR:  pc_d = cond ? (pc_q + target) : pc_seq;
                OP_JMP: pc_d = target;
                OP_CALL: begin
                    if (!ras_full) begin
                        push  = 1'b1;
                        pc_d  = target;
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        pc_d  = pc_seq;
                        err_d = 1'b1;
                    end
                end
                OP_RET: begin
                    if (!ras_empty) begin
                        pc_d  = stack_q[rd_idx];
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        pc_d  = pc_seq;
                        err_d = 1'b1;
                    end
                end
                default: pc_d = pc_seq;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Entries are never cleared: ras_count alone decides what is reachable.
    always_ff @(posedge CLK) begin
        if (push) stack_q[wr_idx] <= pc_seq;
    end

    assign pc        = pc_q;
    assign ras_count = cnt_q;
    assign err       = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: queue-based reference model checked every cycle plus literal pins.
module tb_pc_sequencer;
    localparam int W = 16;
    localparam int S = 1;
    localparam int D = 4;

    logic          CLK = 1'b0;
    logic          Reset = 1'b1;
    logic          en = 1'b0;
    logic [2:0]    op = 3'd0;
    logic          cond = 1'b0;
    logic [W-1:0]  target = '0;
    logic [W-1:0]  pc;
    logic [2:0]    ras_count;
    logic          ras_full, ras_empty, err;

    pc_sequencer #(.WIDTH(W), .STEP(S), .DEPTH(D), .RESET_PC(16'h0000)) dut (
        .CLK(CLK), .Reset(Reset), .en(en), .op(op), .cond(cond), .target(target),
        .pc(pc), .ras_count(ras_count), .ras_full(ras_full), .ras_empty(ras_empty), .err(err)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model: plain integers and a queue used as the return stack.
    int m_pc  = 0;
    int m_err = 0;
    int ras[$];

    function automatic int wrap(input int v);
        return v & ((1 << W) - 1);
    endfunction

    task automatic model_reset();
        m_pc  = 0;
        m_err = 0;
        ras.delete();
    endtask

    task automatic model_apply(input logic [2:0] o, input logic c, input logic [W-1:0] t);
        int nxt;
        nxt = wrap(m_pc + S);
        case (o)
            3'd1: m_pc = c ? wrap(m_pc + int'($signed(t))) : nxt;
            3'd2: m_pc = int'(t);
            3'd3: if (ras.size() < D) begin ras.push_back(nxt); m_pc = int'(t); end
                  else begin m_pc = nxt; m_err = 1; end
            3'd4: if (ras.size() > 0) m_pc = ras.pop_back();
                  else begin m_pc = nxt; m_err = 1; end
            default: m_pc = nxt;
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en && !Reset) begin
            chk("model.pc", 32'(pc), 32'(m_pc));
            chk("model.ras_count", 32'(ras_count), 32'(ras.size()));
            chk("model.ras_full", 32'(ras_full), 32'(ras.size() == D));
            chk("model.ras_empty", 32'(ras_empty), 32'(ras.size() == 0));
            chk("model.err", 32'(err), 32'(m_err));
        end
    end

    task automatic step(input logic e, input logic [2:0] o, input logic c, input logic [W-1:0] t);
        @(negedge CLK);
        en = e; op = o; cond = c; target = t;
        @(posedge CLK);
        if (e) model_apply(o, c, t);
        #1;
    endtask

    // Reset pulsed between edges; outputs must clear without a clock.
    task automatic pulse_reset(input string tag);
        @(posedge CLK);
        #2;
        Reset = 1'b1;
        model_reset();
        #1;
        chk({tag, ".pc"}, 32'(pc), 32'h0);
        chk({tag, ".count"}, 32'(ras_count), 32'h0);
        chk({tag, ".empty"}, 32'(ras_empty), 32'h1);
        chk({tag, ".full"}, 32'(ras_full), 32'h0);
        chk({tag, ".err"}, 32'(err), 32'h0);
        Reset = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst.pc", 32'(pc), 32'h0);
        chk("rst.count", 32'(ras_count), 32'h0);
        chk("rst.empty", 32'(ras_empty), 32'h1);
        chk("rst.full", 32'(ras_full), 32'h0);
        chk("rst.err", 32'(err), 32'h0);
        #1;
        Reset = 1'b0;
        model_reset();
        chk_en = 1'b1;

        for (int i = 0; i < 40; i++) step(1'b1, 3'd0, 1'b0, '0);
        chk("inc40.pc", 32'(pc), 32'd40);
        for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 1'b0, '0);
        chk("stall.pc", 32'(pc), 32'd40);

        step(1'b1, 3'd2, 1'b0, 16'h0010);
        step(1'b1, 3'd1, 1'b1, 16'hFFF0);
        chk("br_taken.pc", 32'(pc), 32'h0000);
        step(1'b1, 3'd2, 1'b0, 16'h0010);
        step(1'b1, 3'd1, 1'b0, 16'hFFF0);
        chk("br_not.pc", 32'(pc), 32'h0011);

        step(1'b1, 3'd2, 1'b0, 16'h0005);
        step(1'b1, 3'd3, 1'b0, 16'h0100);
        step(1'b1, 3'd3, 1'b0, 16'h0200);
        step(1'b1, 3'd3, 1'b0, 16'h0300);
        step(1'b1, 3'd3, 1'b0, 16'h0400);
        chk("call4.full", 32'(ras_full), 32'h1);
        chk("call4.err", 32'(err), 32'h0);
        step(1'b1, 3'd3, 1'b0, 16'h0500);
        chk("call5.err", 32'(err), 32'h1);
        chk("call5.pc", 32'(pc), 32'h0401);
        step(1'b1, 3'd4, 1'b0, '0);
        chk("ret1.pc", 32'(pc), 32'h0301);
        step(1'b1, 3'd4, 1'b0, '0);
        chk("ret2.pc", 32'(pc), 32'h0201);
        step(1'b1, 3'd4, 1'b0, '0);
        chk("ret3.pc", 32'(pc), 32'h0101);
        step(1'b1, 3'd4, 1'b0, '0);
        chk("ret4.pc", 32'(pc), 32'h0006);
        chk("ret4.empty", 32'(ras_empty), 32'h1);

        pulse_reset("rst2");
        step(1'b1, 3'd2, 1'b0, 16'h0020);
        step(1'b1, 3'd4, 1'b0, '0);
        chk("under.pc", 32'(pc), 32'h0021);
        chk("under.err", 32'(err), 32'h1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 3'd0, 1'b0, '0);
            chk("sticky.err", 32'(err), 32'h1);
        end
        chk("sticky.pc", 32'(pc), 32'h002B);

        step(1'b1, 3'd2, 1'b0, 16'hFFFF);
        step(1'b1, 3'd0, 1'b0, '0);
        chk("wrap.pc", 32'(pc), 32'h0000);
        step(1'b1, 3'd2, 1'b0, 16'hFFFE);
        step(1'b1, 3'd0, 1'b0, '0);
        chk("wrap2.pc", 32'(pc), 32'hFFFF);

        // Ops 5-7 advance like INC; stalled CALL must not push.
        step(1'b1, 3'd5, 1'b0, 16'h1234);
        step(1'b1, 3'd6, 1'b1, 16'h1234);
        step(1'b1, 3'd7, 1'b0, 16'h1234);
        chk("op567.pc", 32'(pc), 32'h0002);
        step(1'b0, 3'd3, 1'b0, 16'h0800);
        chk("stallcall.count", 32'(ras_count), 32'h0);

        // Freed slot is overwritten by the next push.
        step(1'b1, 3'd3, 1'b0, 16'h0A00);
        step(1'b1, 3'd4, 1'b0, '0);
        chk("lifo1.pc", 32'(pc), 32'h0003);
        step(1'b1, 3'd2, 1'b0, 16'h0070);
        step(1'b1, 3'd3, 1'b0, 16'h0B00);
        step(1'b1, 3'd4, 1'b0, '0);
        chk("lifo2.pc", 32'(pc), 32'h0071);

        pulse_reset("rst3");
        step(1'b1, 3'd3, 1'b0, 16'h0100);
        step(1'b1, 3'd3, 1'b0, 16'h0200);
        chk("pre_rst.count", 32'(ras_count), 32'h2);
        pulse_reset("rst4");
        step(1'b1, 3'd4, 1'b0, '0);
        chk("post_rst.err", 32'(err), 32'h1);
        chk("post_rst.pc", 32'(pc), 32'h0001);

        @(negedge CLK);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
